// File: rtl/inst_mem_pipe.sv
// inst_mem_pipe: pipelined instruction memory for the MIPS fetch stage.
// Registered 1-cycle read behind a valid/ready request handshake, with
// stall hold, flush (branch redirect), a runtime program-load write port,
// and out-of-range detection that answers with NOP_WORD.
module inst_mem_pipe #(
    parameter int unsigned             DATA_WIDTH = 16,
    parameter int unsigned             ADDR_WIDTH = 16,
    parameter int unsigned             DEPTH      = 256,
    parameter logic [DATA_WIDTH-1:0]   NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] ins,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  addr_err,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

    rsp_state_e              state_q, state_d;
    logic [DATA_WIDTH-1:0]   ins_q, ins_d;
    logic [ADDR_WIDTH-1:0]   rsp_addr_q, rsp_addr_d;
    logic                    addr_err_q, addr_err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    rd_in_range;
    logic                    wr_in_range;
    logic [IDX_W-1:0]        rd_idx;
    logic [IDX_W-1:0]        wr_idx;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Handshake, range checks and array indexing.
    always_comb begin
        req_ready   = !stall && !flush;
        accept      = req_valid && req_ready;
        rd_in_range = ({1'b0, address}   < DEPTH_EXT);
        wr_in_range = ({1'b0, load_addr} < DEPTH_EXT);
        rd_idx      = address[IDX_W-1:0];
        wr_idx      = load_addr[IDX_W-1:0];
        rd_word     = mem[rd_idx];
    end

    // Program-load write port; array is deliberately not reset. The read in
    // the response path samples the same edge, so fetches see the old word.
    always_ff @(posedge clk) begin
        if (load_en && wr_in_range) begin
            mem[wr_idx] <= load_data;
        end
    end

    // Response FSM next state and output-register next values.
    always_comb begin
        state_d    = state_q;
        ins_d      = ins_q;
        rsp_addr_d = rsp_addr_q;
        addr_err_d = addr_err_q;
        if (flush) begin
            state_d    = EMPTY;
            ins_d      = NOP_WORD;
            addr_err_d = 1'b0;
        end else if (stall) begin
            state_d = state_q;
        end else if (accept) begin
            state_d    = FULL;
            rsp_addr_d = address;
            if (rd_in_range) begin
                ins_d      = rd_word;
                addr_err_d = 1'b0;
            end else begin
                ins_d      = NOP_WORD;
                addr_err_d = 1'b1;
            end
        end else begin
            state_d = EMPTY;
        end
    end

    // Response register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            ins_q      <= NOP_WORD;
            rsp_addr_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ins_q      <= ins_d;
            rsp_addr_q <= rsp_addr_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Drive outputs from the response register.
    always_comb begin
        rsp_valid = (state_q == FULL);
        ins       = ins_q;
        rsp_addr  = rsp_addr_q;
        addr_err  = addr_err_q;
    end

endmodule

// File: doc/inst_mem_pipe.md
# inst_mem_pipe

Parametrised, pipelined instruction memory for the pipelined MIPS fetch stage. It is the successor to the combinational-style instruction ROM and adds:
- a registered read with a valid/ready request handshake;
- stall hold and flush (branch redirect) control;
- a runtime program-load write port;
- out-of-range address detection, returning a NOP.

It sits between the PC register and the IF/ID pipeline register.

## Interface
Parameters:
- DATA_WIDTH, 16, instruction word width in bits
- ADDR_WIDTH, 16, word-address width of `address` and `load_addr`
- DEPTH, 256, number of instruction words; power of two, at most 2**ADDR_WIDTH
- NOP_WORD, 16'h0000, word returned on flush, reset or out-of-range access (DATA_WIDTH bits)

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request present
- req_ready  out  1  fetch request can be accepted; equals !stall && !flush (combinational)
- address  in  ADDR_WIDTH  word address of the requested instruction
- stall  in  1  hold the current response; accept no new request
- flush  in  1  discard any in-flight or presented response
- rsp_valid  out  1  `ins` holds a valid fetched word
- ins  out  DATA_WIDTH  fetched instruction
- rsp_addr  out  ADDR_WIDTH  address that produced `ins`
- addr_err  out  1  current response came from address >= DEPTH
- load_en  in  1  write load_data into memory this cycle
- load_addr  in  ADDR_WIDTH  write word address
- load_data  in  DATA_WIDTH  write data

## Operation
- Storage is a DEPTH x DATA_WIDTH array, indexed by the low log2(DEPTH) bits of the address. The array is not cleared by reset.
- Request acceptance (`accept`):
  - `accept` = req_valid && req_ready, sampled at the rising edge.
  - On accept, the output register loads on that edge:
    - in range (address < DEPTH): ins = mem[address], rsp_valid = 1, rsp_addr = address, addr_err = 0;
    - out of range (address >= DEPTH): ins = NOP_WORD, rsp_valid = 1, rsp_addr = address, addr_err = 1.
- No accept and no stall or flush:
  - rsp_valid clears to 0 on the edge;
  - ins, rsp_addr and addr_err hold their values.
- Stall: while stall = 1 (and flush = 0), all outputs hold exactly. The held response is not lost.
- Flush:
  - When flush = 1 at an edge: rsp_valid = 0, ins = NOP_WORD, addr_err = 0, and rsp_addr holds.
  - Flush overrides stall.
  - No request is accepted in a flush cycle, because req_ready is low.
- Load port:
  - When load_en = 1 and load_addr < DEPTH, the edge writes mem[load_addr] = load_data.
  - When load_addr >= DEPTH, the write is ignored.
  - Load is independent of stall and flush.
- Load and fetch to the same address at the same edge: the fetch returns the old (pre-write) word (read-before-write). The next fetch returns the new word.
- Internal state:
  - two-state response FSM: EMPTY (rsp_valid = 0) and FULL (rsp_valid = 1);
  - EMPTY to FULL on accept;
  - FULL to EMPTY on flush, or on no accept with no stall;
  - FULL to FULL on stall, or on accept.

## Timing
- Read latency is 1 cycle: a request accepted at edge N is presented on `ins` from after edge N until edge N+1.
- Throughput is 1 fetch per cycle when stall = 0.
- req_ready is combinational from stall and flush only. It does not depend on req_valid.
- Reset (rst_n low, asynchronous, any time including mid-stall):
  - rsp_valid = 0, ins = NOP_WORD, rsp_addr = 0, addr_err = 0;
  - memory contents are preserved.
- After rst_n deasserts, the first edge with req_valid = 1 and stall = flush = 0 is accepted.
- A load write is visible to a fetch accepted at the edge after the write edge.

## Test plan
- Preload mem[0..3] = 16'h1111, 2222, 3333, 4444 via the load port. Fetch addresses 0, 1, 2, 3 back-to-back -> rsp_valid = 1 for 4 consecutive cycles, with ins = 1111, 2222, 3333, 4444, each one cycle after its request.
- Fetch address 1, then hold stall high for 3 cycles while address = 2 -> ins stays 16'h2222, rsp_addr stays 1 and req_ready = 0 throughout. Address 2 is accepted on the first edge after stall drops.
- Assert stall and flush together while a response is valid -> next edge: rsp_valid = 0, ins = NOP_WORD. Flush wins over stall.
- With DEPTH = 256, fetch address 16'h0100 -> ins = NOP_WORD, addr_err = 1, rsp_valid = 1.
- Same edge: load_en with load_addr = 5, load_data = 16'hBEEF, plus fetch of address 5 (old value 16'h0005) -> ins = 16'h0005. A fetch of address 5 on the following cycle returns 16'hBEEF.
- Pull rst_n low between clock edges during a valid response -> outputs go to reset values immediately, without waiting for an edge. After reset, a fetch of address 0 still returns 16'h1111 (memory preserved).
